// File: rtl/qpoint_lif_neuron.sv
// Leaky integrate-and-fire neuron fed by the Q-point synaptic adder.
// Optional macro LIF_SPIKE_COUNT_EN adds a saturating 16-bit spike counter output.
//
// state     | meaning
// ----------+------------------------------------------------------------
// INTEGRATE | accepting samples; leak, add, saturate, compare to threshold
// REFRACT   | post-spike hold-off; input blocked, membrane held at V_RESET
module qpoint_lif_neuron #(
  parameter int IN_WIDTH      = 9,
  parameter int FRAC          = 4,
  parameter int MEM_WIDTH     = 12,
  parameter int THRESH        = 256,
  parameter int V_RESET       = 0,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_current,
  output logic                        in_ready,
  output logic                        spike,
  output logic signed [MEM_WIDTH-1:0] membrane,
`ifdef LIF_SPIKE_COUNT_EN
  output logic [15:0]                 spike_count,
`endif
  output logic                        refractory
);

  localparam int CW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam logic signed [MEM_WIDTH-1:0] THRESH_M  = MEM_WIDTH'(THRESH);
  localparam logic signed [MEM_WIDTH-1:0] V_RESET_M = MEM_WIDTH'(V_RESET);
  localparam logic [CW-1:0]               REFRAC_M  = CW'(REFRAC_CYCLES);

  // FRAC only documents the Q-point; it must still leave room for an integer part.
  if (MEM_WIDTH <= IN_WIDTH) begin : g_chk_width
    $error("MEM_WIDTH must exceed IN_WIDTH");
  end
  if (FRAC >= IN_WIDTH) begin : g_chk_frac
    $error("FRAC must be smaller than IN_WIDTH");
  end

  typedef enum logic {INTEGRATE = 1'b0, REFRACT = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [MEM_WIDTH-1:0] v_q, v_d;
  logic                        spike_q, spike_d;

  logic signed [MEM_WIDTH-1:0] leak;
  logic signed [MEM_WIDTH:0]   sum;
  logic signed [MEM_WIDTH-1:0] v_next;
  logic                        fire;

  always_comb begin
    leak = v_q >>> LEAK_SHIFT;
    sum  = (MEM_WIDTH+1)'(v_q) - (MEM_WIDTH+1)'(leak) + (MEM_WIDTH+1)'(in_current);
    // Overflow shows up as disagreement between the guard bit and the MEM_WIDTH sign bit.
    if (sum[MEM_WIDTH] != sum[MEM_WIDTH-1]) begin
      v_next = sum[MEM_WIDTH] ? {1'b1, {(MEM_WIDTH-1){1'b0}}}
                              : {1'b0, {(MEM_WIDTH-1){1'b1}}};
    end else begin
      v_next = sum[MEM_WIDTH-1:0];
    end
    fire = (v_next >= THRESH_M);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    spike_d = 1'b0;
    case (state_q)
      INTEGRATE: begin
        if (in_valid) begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = V_RESET_M;
            if (REFRAC_CYCLES > 0) begin
              state_d = REFRACT;
              cnt_d   = REFRAC_M;
            end
          end else begin
            v_d = v_next;
          end
        end
      end
      REFRACT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = INTEGRATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = INTEGRATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INTEGRATE;
      cnt_q   <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] spk_cnt_q, spk_cnt_d;

  always_comb begin
    spk_cnt_d = spk_cnt_q;
    if (spike_d && (spk_cnt_q != 16'hFFFF)) spk_cnt_d = spk_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) spk_cnt_q <= '0;
    else     spk_cnt_q <= spk_cnt_d;
  end

  assign spike_count = spk_cnt_q;
`endif

  assign in_ready   = (state_q == INTEGRATE);
  assign refractory = (state_q == REFRACT);
  assign spike      = spike_q;
  assign membrane   = v_q;

endmodule

// File: tb/tb_qpoint_lif_neuron.sv
// Directed self-checking bench for qpoint_lif_neuron at default parameters.
module tb_qpoint_lif_neuron;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [8:0] in_current;
  logic              in_ready;
  logic              spike;
  logic signed [11:0] membrane;
  logic              refractory;
`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0]       spike_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  qpoint_lif_neuron dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_current (in_current),
    .in_ready   (in_ready),
    .spike      (spike),
    .membrane   (membrane),
`ifdef LIF_SPIKE_COUNT_EN
    .spike_count(spike_count),
`endif
    .refractory (refractory)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic xfer(input int cur);
    in_valid   = 1'b1;
    in_current = 9'(cur);
    tick();
    in_valid   = 1'b0;
  endtask

  // 255 then 40: 255 - 31 + 40 = 264 >= 256, then wait out the 2-cycle hold-off.
  task automatic fire_seq();
    xfer(255);
    xfer(40);
    tick();
    tick();
  endtask

  int m;
  int prev;

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_current = 9'sd100;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_membrane",   membrane,   0);
    chk("rst_spike",      spike,      0);
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_refractory", refractory, 0);

    xfer(64);
    chk("int_64",       membrane, 64);
    chk("int_64_spike", spike,    0);
    repeat (5) tick();
    chk("idle_hold", membrane, 64);
    xfer(0);
    chk("leak_56", membrane, 56);

    do_reset();
    xfer(255);
    chk("pre_fire", membrane, 255);
    in_valid = 1'b1; in_current = 9'sd40;
    tick();
    in_current = 9'sd100;
    chk("fire_spike",  spike,      1);
    chk("fire_memb",   membrane,   0);
    chk("refr1_ready", in_ready,   0);
    chk("refr1_flag",  refractory, 1);
    tick();
    chk("refr2_spike", spike,      0);
    chk("refr2_ready", in_ready,   0);
    chk("refr2_flag",  refractory, 1);
    chk("refr2_memb",  membrane,   0);
    tick();
    in_valid = 1'b0;
    chk("post_ready", in_ready,   1);
    chk("post_flag",  refractory, 0);
    chk("post_memb",  membrane,   0);
    chk("post_spike", spike,      0);

    // Floor-style leak makes the fixed point -2041, short of the saturation rail.
    do_reset();
    m = 0;
    in_valid = 1'b1; in_current = -9'sd256;
    for (int i = 0; i < 60; i++) begin
      prev = membrane;
      tick();
      m = m - (m >>> 3) - 256;
      if (m < -2048) m = -2048;
      chk("neg_model", membrane, m);
      chk("neg_mono",  (membrane <= prev) ? 1 : 0, 1);
      chk("neg_floor", (membrane >= -2048) ? 1 : 0, 1);
      chk("neg_spike", spike, 0);
    end
    chk("neg_settled", membrane, -2041);
    repeat (5) tick();
    chk("neg_hold", membrane, -2041);
    in_valid = 1'b0;

    do_reset();
    xfer(255);
    xfer(40);
    chk("mid_spike", spike, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ready", in_ready,   1);
    chk("mid_flag",  refractory, 0);
    chk("mid_memb",  membrane,   0);
    chk("mid_spike0", spike,     0);

`ifdef LIF_SPIKE_COUNT_EN
    chk("cnt_after_rst", spike_count, 0);
    fire_seq();
    fire_seq();
    fire_seq();
    chk("cnt_three", spike_count, 3);
    do_reset();
    chk("cnt_cleared", spike_count, 0);
`else
    fire_seq();
    chk("refire_memb",  membrane, 0);
    chk("refire_ready", in_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
